output_controller: RTL and testbench

OUTPUT_CONTROLLER -- requirements
Module: output_controller

---
 rtl/output_controller_pkg.sv | 11 +
 rtl/output_controller_if.sv | 26 ++
 rtl/output_controller.sv | 83 ++++++++
 tb/tb_output_controller.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/output_controller_pkg.sv
// Shared constants and state encoding for the result path (input side and output serializer).
package output_controller_pkg;
  localparam int RES_W  = 16;
  localparam int BEATS  = 4;
  localparam int NBYTES = 32;

  typedef enum logic {
    COLLECT = 1'b0,
    SEND    = 1'b1
  } state_e;
endpackage

// File: rtl/output_controller_if.sv
// Result-beat input handshake and serialized byte output handshake.
interface output_controller_if;
  import output_controller_pkg::*;

  logic             res_valid;
  logic             res_ready;
  logic [RES_W-1:0] res1;
  logic [RES_W-1:0] res2;
  logic [RES_W-1:0] res3;
  logic [RES_W-1:0] res4;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             done;
  logic             busy;

  modport slave (
    input  res_valid, res1, res2, res3, res4, out_ready,
    output res_ready, out_data, out_valid, done, busy
  );

  modport master (
    output res_valid, res1, res2, res3, res4, out_ready,
    input  res_ready, out_data, out_valid, done, busy
  );
endinterface

// File: rtl/output_controller.sv
// Collects BEATS result beats into a frame buffer, then streams the frame out as NBYTES bytes.
module output_controller
  import output_controller_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  output_controller_if.slave bus
);
  localparam int BTW = $clog2(BEATS);
  localparam int BCW = $clog2(NBYTES);

  state_e                          r_state;
  logic [BTW-1:0]                  r_beat_cnt;
  logic [BCW-1:0]                  r_byte_cnt;
  logic [0:BEATS-1][4*RES_W-1:0]   r_buf;
  logic [7:0]                      r_out_data;
  logic                            r_out_valid;
  logic                            r_done;
  logic                            r_busy;

  logic [0:NBYTES-1][7:0]          w_bytes;
  logic                            w_res_ready;
  logic                            w_beat_xfer;
  logic                            w_byte_xfer;

  // Row-major buffer, res1 in the top bits of each row, so byte k is simply element k.
  assign w_bytes     = r_buf;
  // Gating with reset_n keeps res_ready low for the whole reset and high right after release.
  assign w_res_ready = reset_n & (r_state == COLLECT);
  assign w_beat_xfer = bus.res_valid & w_res_ready;
  assign w_byte_xfer = r_out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= COLLECT;
      r_beat_cnt  <= '0;
      r_byte_cnt  <= '0;
      r_buf       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        COLLECT: begin
          if (w_beat_xfer) begin
            r_buf[r_beat_cnt] <= {bus.res1, bus.res2, bus.res3, bus.res4};
            r_beat_cnt        <= r_beat_cnt + BTW'(1);
            // Byte 0 lives in row 0, which is already stored when the last beat lands.
            if (r_beat_cnt == BTW'(BEATS-1)) begin
              r_state     <= SEND;
              r_busy      <= 1'b1;
              r_out_valid <= 1'b1;
              r_out_data  <= w_bytes[0];
            end
          end
        end
        SEND: begin
          if (w_byte_xfer) begin
            if (r_byte_cnt == BCW'(NBYTES-1)) begin
              r_state     <= COLLECT;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b0;
              r_done      <= 1'b1;
              r_byte_cnt  <= '0;
              r_beat_cnt  <= '0;
            end else begin
              r_byte_cnt <= r_byte_cnt + BCW'(1);
              r_out_data <= w_bytes[r_byte_cnt + BCW'(1)];
            end
          end
        end
      endcase
    end
  end

  assign bus.res_ready = w_res_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.done      = r_done;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_output_controller.sv
// Directed and randomized frames against a byte-order model of the frame serializer.
module tb_output_controller;
  import output_controller_pkg::*;

  typedef logic [0:BEATS-1][0:3][RES_W-1:0] frame_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  output_controller_if bus();

  output_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte k comes from row k/8, word (k/2)%4, high byte on even k.
  function automatic logic [7:0] exp_byte(input frame_t f, input int k);
    logic [15:0] w;
    w = f[k/8][(k/2)%4];
    return (k % 2 == 0) ? w[15:8] : w[7:0];
  endfunction

  function automatic frame_t rnd_frame();
    frame_t f;
    for (int r = 0; r < BEATS; r++)
      for (int i = 0; i < 4; i++)
        f[r][i] = 16'($urandom);
    return f;
  endfunction

  task automatic put_row(input frame_t f, input int r);
    bus.res1 = f[r][0];
    bus.res2 = f[r][1];
    bus.res3 = f[r][2];
    bus.res4 = f[r][3];
  endtask

  // Called on a falling edge; one beat per cycle, returns on the falling edge after the last.
  task automatic drive_beats(input frame_t f, input int n);
    for (int r = 0; r < n; r++) begin
      bus.res_valid = 1'b1;
      put_row(f, r);
      chk("res_ready_collect", bus.res_ready, 1);
      @(negedge clk);
    end
  endtask

  // mode 0: idle input during SEND; 1: junk beat offered; 2: next frame's row 0 held valid.
  task automatic send_frame(input frame_t f, input int mode, input int stall_at,
                            input bit rnd, input frame_t nxt);
    int k;
    int cyc;
    int st;
    bit rdy;
    k = 0; cyc = 0; st = 0;
    drive_beats(f, BEATS);
    while (k < NBYTES && cyc < 400) begin
      case (mode)
        1: begin
          bus.res_valid = (k < NBYTES-1);
          bus.res1 = 16'hFFFF;
          bus.res2 = 16'($urandom);
        end
        2: begin
          bus.res_valid = 1'b1;
          put_row(nxt, 0);
        end
        default: bus.res_valid = 1'b0;
      endcase
      if (k == stall_at && st < 5) begin
        rdy = 1'b0;
        st++;
      end else begin
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      bus.out_ready = rdy;
      chk("out_valid_send", bus.out_valid, 1);
      chk("out_data", bus.out_data, exp_byte(f, k));
      chk("busy_send", bus.busy, 1);
      chk("res_ready_send", bus.res_ready, 0);
      chk("done_low_send", bus.done, 0);
      if (rdy) k++;
      @(negedge clk);
      cyc++;
    end
    chk("frame_bytes", k, NBYTES);
    chk("done_pulse", bus.done, 1);
    chk("out_valid_after", bus.out_valid, 0);
    chk("busy_after", bus.busy, 0);
    chk("res_ready_done", bus.res_ready, 1);
  endtask

  initial begin
    frame_t fa, fb, fz;
    fz = '0;
    bus.res_valid = 1'b0;
    bus.out_ready = 1'b0;
    put_row(fz, 0);

    repeat (2) @(negedge clk);
    chk("rst_res_ready", bus.res_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    #2 reset_n = 1'b1;
    #1 chk("rel_res_ready", bus.res_ready, 1);
    @(negedge clk);

    // Pattern frame: word w (1-based) of row r reads {r, w, A5}.
    for (int r = 0; r < BEATS; r++)
      for (int i = 0; i < 4; i++)
        fa[r][i] = {4'(r), 4'(i + 1), 8'hA5};
    send_frame(fa, 0, -1, 1'b0, fz);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);

    send_frame(rnd_frame(), 0, 7, 1'b0, fz);
    @(negedge clk);

    send_frame(rnd_frame(), 1, -1, 1'b0, fz);
    bus.res_valid = 1'b0;
    @(negedge clk);
    chk("no_junk_beat", bus.busy, 0);

    fa = rnd_frame();
    fb = rnd_frame();
    send_frame(fa, 2, -1, 1'b0, fb);
    send_frame(fb, 0, 3, 1'b1, fz);

    for (int n = 0; n < 4; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_frame(rnd_frame(), 0, int'($urandom_range(0, 31)), 1'b1, fz);
    end

    // Reset with a partial frame in the buffer.
    drive_beats(rnd_frame(), 2);
    bus.res_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_res_ready", bus.res_ready, 0);
    chk("rst_mid_buf_clear", (dut.r_buf == '0), 1);
    #2 reset_n = 1'b1;
    @(negedge clk);
    send_frame(rnd_frame(), 0, -1, 1'b0, fz);
    @(negedge clk);

    // Reset in the middle of transmission.
    drive_beats(rnd_frame(), BEATS);
    bus.res_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_send_out_valid", bus.out_valid, 0);
    chk("rst_send_busy", bus.busy, 0);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_send_no_done", bus.done, 0);
      chk("rst_send_idle", bus.out_valid, 0);
    end
    send_frame(rnd_frame(), 0, -1, 1'b1, fz);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
